// File: rtl/osc_input_buffer_pkg.sv
// Shared constants and helpers for the oscillator/ZIF input buffer.
package osc_input_buffer_pkg;

  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned FILTER_CYCLES_DEF = 4;
  localparam int unsigned CNT_W             = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  // Count value at which a persistent difference is accepted; 0 and 1 both accept immediately.
  function automatic cnt_t cnt_limit(input int unsigned filter_cycles);
    if (filter_cycles == 0) return '0;
    return CNT_W'(filter_cycles - 1);
  endfunction

endpackage

// File: rtl/ibuf_glitch_filter.sv
// One input bit: synchroniser chain, stability filter and registered edge pulses.
module ibuf_glitch_filter
  import osc_input_buffer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter logic        RESET_VAL     = 1'b0
) (
  input  logic osc,
  input  logic rst,
  input  logic i,
  output logic o_sync,
  output logic o_filt,
  output logic rise,
  output logic fall
);

  localparam cnt_t LIMIT = cnt_limit(FILTER_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  cnt_t                   r_cnt;
  logic                   r_filt;
  logic                   r_rise;
  logic                   r_fall;

  logic w_sync;
  logic w_diff;
  logic w_take;
  cnt_t w_cnt_nxt;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // A difference is accepted once it has persisted for FILTER_CYCLES edges.
  always_comb begin
    w_diff    = w_sync ^ r_filt;
    w_take    = w_diff && (r_cnt == LIMIT);
    w_cnt_nxt = '0;
    if (w_diff && !w_take) w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  always_ff @(posedge osc) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_cnt  <= '0;
      r_filt <= RESET_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i};
      r_cnt  <= w_cnt_nxt;
      r_rise <= w_take &  w_sync;
      r_fall <= w_take & ~w_sync;
      if (w_take) r_filt <= w_sync;
    end
  end

  assign o_sync = w_sync;
  assign o_filt = r_filt;
  assign rise   = r_rise;
  assign fall   = r_fall;

endmodule

// File: rtl/osc_input_buffer.sv
// Pad input buffer: zero-latency pass-through for clock use plus a clocked,
// synchronised and glitch-filtered copy with edge pulses per bit.
module osc_input_buffer
  import osc_input_buffer_pkg::*;
#(
  parameter int unsigned      WIDTH         = 1,
  parameter int unsigned      SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned      FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             osc,
  input  logic             rst,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_filt,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Unregistered so it can drive clock nets independent of osc/rst.
  assign o = i;

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
    ibuf_glitch_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_VAL    (RESET_VAL[g])
    ) u_filt (
      .osc   (osc),
      .rst   (rst),
      .i     (i[g]),
      .o_sync(o_sync[g]),
      .o_filt(o_filt[g]),
      .rise  (rise[g]),
      .fall  (fall[g])
    );
  end

endmodule

// File: tb/tb_osc_input_buffer.sv
// Scoreboard bench: stimulus queues cycle-tagged expectations and edge events,
// a monitor compares them against the three buffer configurations.
module tb_osc_input_buffer;

  logic osc = 1'b0;
  logic clk_en = 1'b0;
  always #5 if (clk_en) osc = ~osc;

  // a: W1 S2 F4; b: W4 F0 RESET_VAL=1010; c: W2 S2 F4
  logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic [0:0] i_a = '0, o_a, o_sync_a, o_filt_a, rise_a, fall_a;
  logic [3:0] i_b = 4'b0101, o_b, o_sync_b, o_filt_b, rise_b, fall_b;
  logic [1:0] i_c = '0, o_c, o_sync_c, o_filt_c, rise_c, fall_c;

  osc_input_buffer #(.WIDTH(1), .SYNC_STAGES(2), .FILTER_CYCLES(4), .RESET_VAL(1'b0)) dut_a (
    .osc(osc), .rst(rst_a), .i(i_a), .o(o_a), .o_sync(o_sync_a), .o_filt(o_filt_a),
    .rise(rise_a), .fall(fall_a));

  osc_input_buffer #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(0), .RESET_VAL(4'b1010)) dut_b (
    .osc(osc), .rst(rst_b), .i(i_b), .o(o_b), .o_sync(o_sync_b), .o_filt(o_filt_b),
    .rise(rise_b), .fall(fall_b));

  osc_input_buffer #(.WIDTH(2), .SYNC_STAGES(2), .FILTER_CYCLES(4), .RESET_VAL(2'b00)) dut_c (
    .osc(osc), .rst(rst_c), .i(i_c), .o(o_c), .o_sync(o_sync_c), .o_filt(o_filt_c),
    .rise(rise_c), .fall(fall_c));

  typedef struct {
    int         cyc;
    int         id;
    int         sig;
    logic [3:0] val;
    string      name;
  } exp_t;

  typedef struct {
    int         cyc;
    int         id;
    logic [3:0] r;
    logic [3:0] f;
  } ev_t;

  exp_t expq[$];
  ev_t  evq[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // sig: 0 o_sync, 1 o_filt, 2 rise, 3 fall
  function automatic logic [3:0] dut_val(input int id, input int sig);
    logic [3:0] v;
    v = 'x;
    case (id)
      0: case (sig)
           0: v = 4'(o_sync_a); 1: v = 4'(o_filt_a); 2: v = 4'(rise_a); default: v = 4'(fall_a);
         endcase
      1: case (sig)
           0: v = o_sync_b; 1: v = o_filt_b; 2: v = rise_b; default: v = fall_b;
         endcase
      default: case (sig)
           0: v = 4'(o_sync_c); 1: v = 4'(o_filt_c); 2: v = 4'(rise_c); default: v = 4'(fall_c);
         endcase
    endcase
    return v;
  endfunction

  task automatic exp_at(input int d, input int id, input int sig, input logic [3:0] v,
                        input string name);
    exp_t e;
    e.cyc = cyc + d; e.id = id; e.sig = sig; e.val = v; e.name = name;
    expq.push_back(e);
  endtask

  task automatic ev_at(input int d, input int id, input logic [3:0] r, input logic [3:0] f);
    ev_t e;
    e.cyc = cyc + d; e.id = id; e.r = r; e.f = f;
    evq.push_back(e);
  endtask

  task automatic pop_ev(input int id, input logic [3:0] r, input logic [3:0] f);
    int k;
    k = -1;
    for (int j = 0; j < evq.size(); j++)
      if (k < 0 && evq[j].id == id) k = j;
    if (k < 0) begin
      check($sformatf("unexpected_edge_dut%0d", id), {24'd0, r, f}, 32'd0);
    end else begin
      check($sformatf("edge_cycle_dut%0d", id), 32'(cyc), 32'(evq[k].cyc));
      check($sformatf("edge_rise_dut%0d", id), 32'(r), 32'(evq[k].r));
      check($sformatf("edge_fall_dut%0d", id), 32'(f), 32'(evq[k].f));
      evq.delete(k);
    end
  endtask

  // Monitor: sample 2 time units after each rising edge.
  always @(posedge osc) begin
    int k;
    logic [3:0] r, f;
    cyc++;
    #2;
    k = 0;
    while (k < expq.size()) begin
      if (expq[k].cyc == cyc) begin
        check(expq[k].name, 32'(dut_val(expq[k].id, expq[k].sig)), 32'(expq[k].val));
        expq.delete(k);
      end else begin
        k++;
      end
    end
    for (int id = 0; id < 3; id++) begin
      r = dut_val(id, 2);
      f = dut_val(id, 3);
      if ((r | f) != 4'd0) pop_ev(id, r, f);
    end
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge osc);
  endtask

  task automatic drive_a(input logic v);
    i_a = v;
    #1 check("pass_a", 32'(o_a), 32'(v));
  endtask

  initial begin
    // Pass-through with clock stopped and reset held.
    drive_a(1'b1); #3;
    drive_a(1'b0); #3;
    drive_a(1'bx); #3;
    drive_a(1'b0);
    i_c = 2'b01; #1 check("pass_c", 32'(o_c), 32'(2'b01));
    i_c = 2'b10; #1 check("pass_c", 32'(o_c), 32'(2'b10));
    i_c = 2'b00; #1 check("pass_b", 32'(o_b), 32'(4'b0101));

    clk_en = 1'b1;
    nclk(2);
    exp_at(1, 0, 0, 4'd0, "rst_sync_a");
    exp_at(1, 0, 1, 4'd0, "rst_filt_a");
    exp_at(1, 0, 2, 4'd0, "rst_rise_a");
    exp_at(1, 1, 0, 4'b1010, "rst_sync_b");
    exp_at(1, 1, 1, 4'b1010, "rst_filt_b");
    exp_at(1, 1, 2, 4'd0, "rst_rise_b");
    nclk(1);
    rst_a = 1'b0;
    rst_c = 1'b0;
    nclk(3);

    // Latency: rise then fall.
    drive_a(1'b1);
    exp_at(1, 0, 0, 4'd0, "lat_sync_1");
    exp_at(2, 0, 0, 4'd1, "lat_sync_2");
    exp_at(5, 0, 1, 4'd0, "lat_filt_5");
    exp_at(6, 0, 1, 4'd1, "lat_filt_6");
    exp_at(6, 0, 2, 4'd1, "lat_rise_6");
    exp_at(7, 0, 2, 4'd0, "lat_rise_7");
    ev_at(6, 0, 4'd1, 4'd0);
    nclk(10);
    drive_a(1'b0);
    exp_at(5, 0, 1, 4'd1, "lat_ffilt_5");
    exp_at(6, 0, 1, 4'd0, "lat_ffilt_6");
    exp_at(6, 0, 3, 4'd1, "lat_fall_6");
    exp_at(7, 0, 3, 4'd0, "lat_fall_7");
    ev_at(6, 0, 4'd0, 4'd1);
    nclk(10);

    // Glitch rejection: 3 cycles dropped, 4 cycles accepted.
    drive_a(1'b1);
    exp_at(2, 0, 0, 4'd1, "gl_sync_2");
    exp_at(4, 0, 0, 4'd1, "gl_sync_4");
    exp_at(5, 0, 0, 4'd0, "gl_sync_5");
    exp_at(6, 0, 1, 4'd0, "gl_filt_6");
    exp_at(8, 0, 1, 4'd0, "gl_filt_8");
    nclk(3);
    drive_a(1'b0);
    nclk(10);
    drive_a(1'b1);
    exp_at(5, 0, 1, 4'd0, "gl4_filt_5");
    exp_at(6, 0, 1, 4'd1, "gl4_filt_6");
    ev_at(6, 0, 4'd1, 4'd0);
    nclk(4);
    drive_a(1'b0);
    exp_at(6, 0, 1, 4'd0, "gl4_filt_fall");
    ev_at(6, 0, 4'd0, 4'd1);
    nclk(12);

    // Reset mid-count aborts the pending change.
    drive_a(1'b1);
    exp_at(4, 0, 0, 4'd1, "rm_sync_pre");
    nclk(4);
    rst_a = 1'b1;
    exp_at(1, 0, 0, 4'd0, "rm_sync");
    exp_at(1, 0, 1, 4'd0, "rm_filt");
    exp_at(1, 0, 2, 4'd0, "rm_rise");
    exp_at(1, 0, 3, 4'd0, "rm_fall");
    exp_at(2, 0, 1, 4'd0, "rm_abort");
    nclk(1);
    rst_a = 1'b0;
    exp_at(5, 0, 1, 4'd0, "rm_filt_5");
    exp_at(6, 0, 1, 4'd1, "rm_filt_6");
    ev_at(6, 0, 4'd1, 4'd0);
    nclk(10);
    drive_a(1'b0);
    ev_at(6, 0, 4'd0, 4'd1);
    nclk(10);

    // RESET_VAL with filter bypass.
    rst_b = 1'b0;
    exp_at(1, 1, 1, 4'b1010, "rv_filt_1");
    exp_at(2, 1, 1, 4'b1010, "rv_filt_2");
    exp_at(2, 1, 0, 4'b0101, "rv_sync_2");
    exp_at(3, 1, 1, 4'b0101, "rv_filt_3");
    exp_at(3, 1, 2, 4'b0101, "rv_rise_3");
    exp_at(3, 1, 3, 4'b1010, "rv_fall_3");
    exp_at(4, 1, 2, 4'b0000, "rv_rise_4");
    exp_at(4, 1, 3, 4'b0000, "rv_fall_4");
    ev_at(3, 1, 4'b0101, 4'b1010);
    nclk(6);

    // Independent bits: bit0 glitches while bit1 steps up.
    i_c = 2'b11;
    exp_at(2, 2, 0, 4'b0011, "ind_sync_2");
    exp_at(4, 2, 0, 4'b0010, "ind_sync_4");
    exp_at(5, 2, 1, 4'b0000, "ind_filt_5");
    exp_at(6, 2, 1, 4'b0010, "ind_filt_6");
    exp_at(6, 2, 2, 4'b0010, "ind_rise_6");
    exp_at(6, 2, 3, 4'b0000, "ind_fall_6");
    exp_at(7, 2, 2, 4'b0000, "ind_rise_7");
    exp_at(9, 2, 1, 4'b0010, "ind_filt_9");
    ev_at(6, 2, 4'b0010, 4'b0000);
    nclk(2);
    i_c = 2'b10;
    nclk(12);

    foreach (expq[k]) check($sformatf("missed_%s", expq[k].name), 32'd1, 32'd0);
    foreach (evq[k]) check($sformatf("missing_edge_dut%0d", evq[k].id), 32'(evq[k].cyc), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
